data_io_fifo: RTL

Parametrised successor to the MiST-style SPI data_io link between the ARM io controller and the core. It samples the SPI slave interface in the clk_sys domain and decodes controller commands: config string, status word, file index, ACK and data read-back. Download bytes are packed into words of DATA_W bits and buffered in a FIFO, so the core can stall the stream with ioctl_wait without losing data.

---
 rtl/data_io_fifo.sv | 285 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/data_io_fifo.sv
// data_io_fifo: SPI data_io link between the io controller and the core.
// SPI inputs are synchronised into clk_sys; commands decoded per frame:
// ACK, data read-back, config string, status word, file index and
// download start/end. Download bytes are packed into DATA_W-bit words and
// buffered in a FIFO so the core can stall with ioctl_wait.
// Ports:
//   clk_sys, reset_n            system clock, async active-low reset
//   SPI_SCK/SS2/DI/DO           SPI slave, mode 0, SPI_DO Z when deselected
//   data_in                     byte returned for command 0x10
//   conf_str                    config string, first character in MSBs
//   status                      menu status word loaded by command 0x15
//   ioctl_wait                  core stall, blocks FIFO pops
//   ioctl_download/index/wr/addr/dout/last/overflow  download interface
module data_io_fifo #(
  parameter int STRLEN     = 0,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 25,
  parameter int FIFO_DEPTH = 8,
  parameter int STATUS_W   = 32
) (
  input  logic                                       clk_sys,
  input  logic                                       reset_n,
  input  logic                                       SPI_SCK,
  input  logic                                       SPI_SS2,
  input  logic                                       SPI_DI,
  output logic                                       SPI_DO,
  input  logic [7:0]                                 data_in,
  input  logic [((STRLEN > 0) ? 8*STRLEN : 8)-1:0]   conf_str,
  output logic [STATUS_W-1:0]                        status,
  input  logic                                       ioctl_wait,
  output logic                                       ioctl_download,
  output logic [7:0]                                 ioctl_index,
  output logic                                       ioctl_wr,
  output logic [ADDR_W-1:0]                          ioctl_addr,
  output logic [DATA_W-1:0]                          ioctl_dout,
  output logic [ADDR_W-1:0]                          ioctl_last,
  output logic                                       ioctl_overflow
);

  localparam int BYTES  = DATA_W / 8;
  localparam int SBYTES = STATUS_W / 8;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int BC_W   = $clog2(STRLEN + SBYTES + 2) + 1;
  localparam int EW     = ADDR_W + DATA_W;
  localparam logic [2:0] PACK_LAST = 3'(BYTES - 1);

  typedef enum logic [7:0] {
    CMD_ACK      = 8'h00,
    CMD_DATA     = 8'h10,
    CMD_CONF     = 8'h14,
    CMD_STATUS   = 8'h15,
    CMD_INDEX    = 8'h55,
    CMD_DL_START = 8'h61,
    CMD_DL_END   = 8'h62
  } cmd_e;

  // input synchronisers and SCK edge history
  logic r_sck_m, r_sck_s, r_sck_d;
  logic r_ss_m, r_ss_s;
  logic r_di_m, r_di_s;

  // SPI shift state
  logic [2:0]      r_bit_cnt;
  logic [BC_W-1:0] r_byte_cnt;
  logic [6:0]      r_sr;
  logic [6:0]      r_tx;
  logic            r_do;
  logic            r_do_en;
  logic [7:0]      r_cmd;

  // download state
  logic              r_download;
  logic              r_draining;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_pack;
  logic [2:0]        r_pack_cnt;
  logic [ADDR_W-1:0] r_last;
  logic              r_overflow;
  logic [7:0]        r_index;
  logic [STATUS_W-1:0] r_status;

  // FIFO
  logic [EW-1:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [AW:0]       r_count;
  logic              r_wr;
  logic [ADDR_W-1:0] r_ioaddr;
  logic [DATA_W-1:0] r_dout;

  logic              w_sck_rise, w_sck_fall, w_byte_done, w_is_cmd;
  logic [7:0]        w_byte, w_tx;
  logic [BC_W-1:0]   w_pidx;
  logic [DATA_W-1:0] w_pack_ins;
  logic              w_pack_last;
  logic              w_push, w_pop, w_store, w_empty, w_full;
  logic [EW-1:0]     w_push_data;
  logic              w_unused_conf;

  assign w_sck_rise  = r_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~r_sck_s & r_sck_d;
  assign w_byte      = {r_sr, r_di_s};
  assign w_byte_done = ~r_ss_s & w_sck_rise & (r_bit_cnt == 3'd7);
  assign w_is_cmd    = (r_byte_cnt == '0);
  assign w_pidx      = r_byte_cnt - BC_W'(1);
  assign w_pack_ins  = r_pack | (DATA_W'(w_byte) << {r_pack_cnt, 3'b000});
  assign w_pack_last = (r_pack_cnt == PACK_LAST);
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop       = ~w_empty & ~ioctl_wait;
  // a push into a full FIFO survives only if a pop frees a slot this cycle
  assign w_store     = w_push & (~w_full | w_pop);
  assign w_unused_conf = ^conf_str;

  // words leave the packer on the last byte of a word, or zero-padded on 0x62
  always_comb begin
    w_push      = 1'b0;
    w_push_data = {r_addr, w_pack_ins};
    if (w_byte_done && r_download) begin
      if (!w_is_cmd && r_cmd == CMD_DL_START && w_pack_last) begin
        w_push = 1'b1;
      end
      if (w_is_cmd && w_byte == CMD_DL_END && r_pack_cnt != 3'd0) begin
        w_push      = 1'b1;
        w_push_data = {r_addr, r_pack};
      end
    end
  end

  // byte to transmit during payload byte r_byte_cnt-1
  always_comb begin
    w_tx = '0;
    if (!w_is_cmd) begin
      case (r_cmd)
        CMD_ACK:  w_tx = 8'h4B;
        CMD_DATA: w_tx = data_in;
        CMD_CONF: begin
          for (int unsigned k = 0; k < STRLEN; k++) begin
            if (w_pidx == BC_W'(k)) w_tx = conf_str[8*(STRLEN-1-k) +: 8];
          end
        end
        default:  w_tx = '0;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (w_store) r_mem[r_wp] <= w_push_data;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_sck_m <= 1'b0; r_sck_s <= 1'b0; r_sck_d <= 1'b0;
      r_ss_m  <= 1'b1; r_ss_s  <= 1'b1;
      r_di_m  <= 1'b0; r_di_s  <= 1'b0;
      r_bit_cnt  <= '0;
      r_byte_cnt <= '0;
      r_sr       <= '0;
      r_tx       <= '0;
      r_do       <= 1'b0;
      r_do_en    <= 1'b0;
      r_cmd      <= '0;
      r_download <= 1'b0;
      r_draining <= 1'b0;
      r_addr     <= '0;
      r_pack     <= '0;
      r_pack_cnt <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
      r_index    <= '0;
      r_status   <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_count    <= '0;
      r_wr       <= 1'b0;
      r_ioaddr   <= '0;
      r_dout     <= '0;
    end else begin
      r_sck_m <= SPI_SCK; r_sck_s <= r_sck_m; r_sck_d <= r_sck_s;
      r_ss_m  <= SPI_SS2; r_ss_s  <= r_ss_m;
      r_di_m  <= SPI_DI;  r_di_s  <= r_di_m;

      // FIFO side
      r_wr <= w_pop;
      if (w_pop) begin
        {r_ioaddr, r_dout} <= r_mem[r_rp];
        r_rp <= r_rp + AW'(1);
      end
      if (w_store) r_wp <= r_wp + AW'(1);
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_store) r_overflow <= 1'b1;

      // SPI shifting
      if (r_ss_s) begin
        r_bit_cnt  <= '0;
        r_byte_cnt <= '0;
        r_tx       <= '0;
        r_do_en    <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_sr      <= {r_sr[5:0], r_di_s};
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7 && r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + BC_W'(1);
        end
        if (w_sck_fall) begin
          r_do_en <= 1'b1;
          if (r_bit_cnt == 3'd0) begin
            r_do <= w_tx[7];
            r_tx <= w_tx[6:0];
          end else begin
            r_do <= r_tx[6];
            r_tx <= {r_tx[5:0], 1'b0};
          end
        end
      end

      // drain completes the cycle after the FIFO is seen empty; a byte
      // event in the same cycle (e.g. a new 0x61) takes precedence
      if (r_draining && w_empty && !w_byte_done) begin
        r_download <= 1'b0;
        r_draining <= 1'b0;
      end

      if (w_byte_done) begin
        if (w_is_cmd) begin
          r_cmd <= w_byte;
          if (w_byte == CMD_DL_START) begin
            r_draining <= 1'b0;
            if (!r_download) begin
              r_download <= 1'b1;
              r_addr     <= '0;
              r_pack     <= '0;
              r_pack_cnt <= '0;
              r_overflow <= 1'b0;
            end
          end else if (w_byte == CMD_DL_END && r_download) begin
            r_addr     <= r_addr + ADDR_W'(r_pack_cnt);
            r_last     <= r_addr + ADDR_W'(r_pack_cnt);
            r_pack     <= '0;
            r_pack_cnt <= '0;
            r_draining <= 1'b1;
          end
        end else begin
          case (r_cmd)
            CMD_STATUS: begin
              for (int unsigned k = 0; k < SBYTES; k++) begin
                if (w_pidx == BC_W'(k)) r_status[8*(SBYTES-1-k) +: 8] <= w_byte;
              end
            end
            CMD_INDEX: begin
              if (w_pidx == '0) r_index <= w_byte;
            end
            CMD_DL_START: begin
              if (r_download) begin
                if (w_pack_last) begin
                  r_pack     <= '0;
                  r_pack_cnt <= '0;
                  r_addr     <= r_addr + ADDR_W'(BYTES);
                end else begin
                  r_pack     <= w_pack_ins;
                  r_pack_cnt <= r_pack_cnt + 3'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign SPI_DO         = r_do_en ? r_do : 1'bz;
  assign status         = r_status;
  assign ioctl_download = r_download;
  assign ioctl_index    = r_index;
  assign ioctl_wr       = r_wr;
  assign ioctl_addr     = r_ioaddr;
  assign ioctl_dout     = r_dout;
  assign ioctl_last     = r_last;
  assign ioctl_overflow = r_overflow;

endmodule
